// File: rtl/cipher_stream_ctrl.sv
// cipher_stream_ctrl: per-message Caesar sequencer with a shared decrypt unit and an output FIFO
module cipher_stream_ctrl #(
    parameter int DEPTH = 4,
    parameter int MSG_MAX = 16,
    localparam int LW = $clog2(MSG_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_mode,
    input  logic [7:0]    i_key,
    input  logic [LW-1:0] i_len,
    input  logic          i_in_valid,
    input  logic [7:0]    i_in_data,
    output logic          o_in_ready,
    output logic          o_out_valid,
    output logic [7:0]    o_out_data,
    output logic          o_out_last,
    input  logic          i_out_ready,
    output logic          o_busy,
    output logic          o_done
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_done, w_done_nxt;
    logic [7:0]    r_shift;
    logic [LW-1:0] r_rem;
    logic [8:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          w_full, w_wr, w_rd;
    logic [8:0]    w_head;
    logic [7:0]    w_s26, w_s10;

    // Shifts backwards within the char's class (A-Z, a-z, 0-9); anything else passes through.
    function automatic logic [7:0] f_dec(input logic [7:0] c, input logic [7:0] s26,
                                         input logic [7:0] s10);
        logic [7:0] b, m, s, o;
        b = 8'd0;
        m = 8'd26;
        s = s26;
        if (c >= "A" && c <= "Z") b = "A";
        else if (c >= "a" && c <= "z") b = "a";
        else if (c >= "0" && c <= "9") begin
            b = "0";
            m = 8'd10;
            s = s10;
        end
        o = c - b;
        return (b == 8'd0) ? c : b + ((o >= s) ? o - s : o + m - s);
    endfunction

    assign w_s26       = r_shift % 8'd26;
    assign w_s10       = r_shift % 8'd10;
    assign w_full      = r_cnt == CW'(DEPTH);
    assign o_out_valid = r_cnt != '0;
    assign w_head      = r_mem[r_rd_ptr];
    assign o_out_data  = o_out_valid ? w_head[7:0] : 8'd0;
    assign o_out_last  = o_out_valid & w_head[8];
    assign w_wr        = i_in_valid & o_in_ready;
    assign w_rd        = o_out_valid & i_out_ready;
    assign o_busy      = r_state != IDLE;
    assign o_done      = r_done;

    // State register and the registered done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next state, done request and input-side ready.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        o_in_ready  = (r_state == RUN) && !w_full && (r_rem != '0);
        case (r_state)
            IDLE: if (i_start) begin
                if (i_len == '0) w_done_nxt = 1'b1;
                else w_state_nxt = RUN;
            end
            RUN: if (w_wr && r_rem == LW'(1)) w_state_nxt = DRAIN;
            DRAIN: if (w_rd && w_head[8]) begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Per-message shift and remaining-char count; encrypt uses a shift congruent to -key.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= 8'd0;
            r_rem   <= '0;
        end else if (r_state == IDLE && i_start) begin
            r_shift <= i_mode ? (8'd130 - (i_key % 8'd130)) % 8'd130 : i_key;
            r_rem   <= i_len;
        end else if (w_wr) begin
            r_rem   <= r_rem - LW'(1);
        end
    end

    // FIFO storage; stale entries are never visible since the head is gated by occupancy.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= {r_rem == LW'(1), f_dec(i_in_data, w_s26, w_s10)};
    end

    // FIFO pointers and occupancy; concurrent read and write leave occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
        end
    end
endmodule

// File: tb/tb_cipher_stream_ctrl.sv
// tb_cipher_stream_ctrl: directed vectors and corner sequences for cipher_stream_ctrl
module tb_cipher_stream_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0, i_mode = 1'b0, i_in_valid = 1'b0, i_out_ready = 1'b0;
    logic [7:0] i_key = 8'd0, i_in_data = 8'd0;
    logic [4:0] i_len = 5'd0;
    logic       o_in_ready, o_out_valid, o_out_last, o_busy, o_done;
    logic [7:0] o_out_data;

    int n_cmp = 0;
    int n_bad = 0;
    logic cap = 1'b0;
    logic [8:0] cap_q[$];

    typedef struct {logic m; logic [7:0] k; logic [7:0] c; logic [7:0] e;} vec_t;
    vec_t vt[15];

    cipher_stream_ctrl #(.DEPTH(4), .MSG_MAX(16)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_mode(i_mode), .i_key(i_key), .i_len(i_len),
        .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
        .o_out_valid(o_out_valid), .o_out_data(o_out_data), .o_out_last(o_out_last),
        .i_out_ready(i_out_ready), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cap && o_out_valid && i_out_ready) cap_q.push_back({o_out_last, o_out_data});

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start_msg(input logic m, input logic [7:0] k, input logic [4:0] l);
        i_start = 1'b1;
        i_mode = m;
        i_key = k;
        i_len = l;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        i_mode = ~m;
        i_key = ~k;
        i_len = 5'd1;
    endtask

    task automatic send_char(input logic [7:0] c);
        int t = 0;
        i_in_valid = 1'b1;
        i_in_data = c;
        while (!o_in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t == 50) chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        i_in_valid = 1'b0;
    endtask

    task automatic pop_char(input string nm, input logic [7:0] e, input logic l);
        int t = 0;
        while (!o_out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_data"}, o_out_data, e);
        chk({nm, "_last"}, o_out_last, l);
        i_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_out_ready = 1'b0;
    endtask

    initial begin
        vt[0]  = '{1'b0, 8'd3, "D", "A"};
        vt[1]  = '{1'b0, 8'd3, "1", "8"};
        vt[2]  = '{1'b0, 8'd3, "a", "x"};
        vt[3]  = '{1'b1, 8'd3, "A", "D"};
        vt[4]  = '{1'b1, 8'd3, "z", "c"};
        vt[5]  = '{1'b1, 8'd3, "9", "2"};
        vt[6]  = '{1'b1, 8'd3, "#", "#"};
        vt[7]  = '{1'b0, 8'd255, "A", "F"};
        vt[8]  = '{1'b0, 8'd255, "0", "5"};
        vt[9]  = '{1'b0, 8'd0, "Q", "Q"};
        vt[10] = '{1'b1, 8'd255, "A", "V"};
        vt[11] = '{1'b1, 8'd130, "m", "m"};
        vt[12] = '{1'b0, 8'd26, "Z", "Z"};
        vt[13] = '{1'b0, 8'd3, "@", "@"};
        vt[14] = '{1'b0, 8'd3, "{", "{"};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", o_in_ready, 0);
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_out_data", o_out_data, 0);
        chk("rst_out_last", o_out_last, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            start_msg(vt[i].m, vt[i].k, 5'd1);
            send_char(vt[i].c);
            chk($sformatf("vec%0d_latency", i), o_out_valid, 1);
            pop_char($sformatf("vec%0d", i), vt[i].e, 1'b1);
            chk($sformatf("vec%0d_done", i), o_done, 1);
            chk($sformatf("vec%0d_busy", i), o_busy, 0);
        end

        start_msg(1'b0, 8'd3, 5'd3);
        send_char("D");
        send_char("1");
        send_char("a");
        chk("t2_drain_in_ready", o_in_ready, 0);
        chk("t2_drain_busy", o_busy, 1);
        pop_char("t2_c0", "A", 1'b0);
        chk("t2_no_early_done", o_done, 0);
        pop_char("t2_c1", "8", 1'b0);
        pop_char("t2_c2", "x", 1'b1);
        chk("t2_done", o_done, 1);
        chk("t2_busy", o_busy, 0);
        @(negedge clk);
        chk("t2_done_one_cycle", o_done, 0);

        i_out_ready = 1'b1;
        cap = 1'b1;
        start_msg(1'b1, 8'd3, 5'd4);
        send_char("A");
        send_char("z");
        send_char("9");
        send_char("#");
        for (int t = 0; t < 20 && !o_done; t++) @(negedge clk);
        chk("t3_done_seen", o_done, 1);
        cap = 1'b0;
        i_out_ready = 1'b0;
        chk("t3_count", cap_q.size(), 4);
        if (cap_q.size() == 4) begin
            chk("t3_b0", cap_q[0], {1'b0, 8'h44});
            chk("t3_b1", cap_q[1], {1'b0, 8'h63});
            chk("t3_b2", cap_q[2], {1'b0, 8'h32});
            chk("t3_b3", cap_q[3], {1'b1, 8'h23});
        end
        @(negedge clk);

        start_msg(1'b0, 8'd0, 5'd6);
        send_char("a");
        send_char("b");
        send_char("c");
        send_char("d");
        chk("t5_full_in_ready", o_in_ready, 0);
        chk("t5_full_busy", o_busy, 1);
        repeat (2) @(negedge clk);
        chk("t5_full_hold_data", o_out_data, "a");
        chk("t5_full_hold_ready", o_in_ready, 0);
        pop_char("t5_c0", "a", 1'b0);
        send_char("e");
        pop_char("t5_c1", "b", 1'b0);
        send_char("f");
        chk("t5_drain_in_ready", o_in_ready, 0);
        pop_char("t5_c2", "c", 1'b0);
        chk("t5_drain_in_ready2", o_in_ready, 0);
        pop_char("t5_c3", "d", 1'b0);
        pop_char("t5_c4", "e", 1'b0);
        pop_char("t5_c5", "f", 1'b1);
        chk("t5_done", o_done, 1);
        chk("t5_empty", o_out_valid, 0);
        @(negedge clk);

        start_msg(1'b0, 8'd3, 5'd4);
        send_char("D");
        start_msg(1'b1, 8'd0, 5'd1);
        chk("t6_ignored_busy", o_busy, 1);
        chk("t6_ignored_in_ready", o_in_ready, 1);
        send_char("E");
        chk("t6_len_kept", o_in_ready, 1);
        pop_char("t6_c0", "A", 1'b0);
        chk("t6_key_kept", o_out_data, "B");
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_out_valid", o_out_valid, 0);
        chk("t6_rst_busy", o_busy, 0);
        chk("t6_rst_in_ready", o_in_ready, 0);
        chk("t6_rst_done", o_done, 0);
        @(negedge clk);
        chk("t6_rst_no_done", o_done, 0);
        chk("t6_rst_still_empty", o_out_valid, 0);

        start_msg(1'b1, 8'd9, 5'd0);
        chk("t6_len0_done", o_done, 1);
        chk("t6_len0_busy", o_busy, 0);
        chk("t6_len0_out_valid", o_out_valid, 0);
        @(negedge clk);
        chk("t6_len0_done_once", o_done, 0);
        chk("t6_len0_no_beats", o_out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
